// File: rtl/midi_parser.sv
// MIDI channel-voice parser: decodes a byte stream into note-on/note-off events with
// running status, SysEx skipping, real-time byte transparency and a channel filter.
module midi_parser #(
    parameter bit VEL0_IS_OFF = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       byteValid_i,
    input  logic [7:0] byte_i,
    input  logic [3:0] chanFilter_i,
    input  logic       omniEn_i,
    output logic       noteOn_o,
    output logic       noteOff_o,
    output logic [6:0] note_o,
    output logic [6:0] velocity_o,
    output logic [3:0] channel_o,
    output logic       gate_o,
    output logic       error_o
);

    typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSysex} state_e;

    state_e     state;
    logic       validPrev;
    logic [3:0] kind;
    logic [3:0] statusChan;
    logic [6:0] data1;
    logic [6:0] lastOnNote;

    logic       accept;
    logic       isRealTime;
    logic       isChanStatus;
    logic       oneData;
    logic       complete;
    logic [6:0] data2;
    logic       chanMatch;
    logic       noteEvent;
    logic       isOff;

    // Byte classification and message-completion decode for the current byte.
    always_comb begin
        accept       = byteValid_i & ~validPrev;
        isRealTime   = (byte_i[7:3] == 5'b11111);
        isChanStatus = byte_i[7] & (byte_i[7:4] != 4'hF);
        oneData      = (kind == 4'hC) || (kind == 4'hD);
        complete     = accept && !byte_i[7] &&
                       ((state == StWaitD1 && oneData) || state == StWaitD2);
        data2        = (state == StWaitD2) ? byte_i[6:0] : 7'd0;
        chanMatch    = omniEn_i || (statusChan == chanFilter_i);
        noteEvent    = complete && ((kind == 4'h8) || (kind == 4'h9)) && chanMatch;
        isOff        = (kind == 4'h8) || (VEL0_IS_OFF && (data2 == 7'd0));
    end

    // Parser FSM with registered event outputs; pulses default low every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= StIdle;
            validPrev  <= 1'b1;  // a byte already valid at reset release is not accepted
            kind       <= 4'h0;
            statusChan <= 4'h0;
            data1      <= 7'd0;
            lastOnNote <= 7'd0;
            noteOn_o   <= 1'b0;
            noteOff_o  <= 1'b0;
            error_o    <= 1'b0;
            note_o     <= 7'd0;
            velocity_o <= 7'd0;
            channel_o  <= 4'h0;
            gate_o     <= 1'b0;
        end else begin
            validPrev <= byteValid_i;
            noteOn_o  <= 1'b0;
            noteOff_o <= 1'b0;
            error_o   <= 1'b0;
            if (accept && !isRealTime) begin
                if (isChanStatus) begin
                    kind       <= byte_i[7:4];
                    statusChan <= byte_i[3:0];
                    state      <= StWaitD1;
                end else if (byte_i[7]) begin
                    // System common: F0 enters SysEx, F1-F7 drop running status.
                    state <= (byte_i == 8'hF0) ? StSysex : StIdle;
                end else begin
                    unique case (state)
                        StIdle:   error_o <= 1'b1;
                        StWaitD1: begin
                            data1 <= byte_i[6:0];
                            if (!oneData) state <= StWaitD2;
                        end
                        StWaitD2: state <= StWaitD1;
                        StSysex:  ;
                    endcase
                end
                if (noteEvent) begin
                    note_o     <= data1;
                    velocity_o <= data2;
                    channel_o  <= statusChan;
                    if (isOff) begin
                        noteOff_o <= 1'b1;
                        if (data1 == lastOnNote) gate_o <= 1'b0;
                    end else begin
                        noteOn_o   <= 1'b1;
                        gate_o     <= 1'b1;
                        lastOnNote <= data1;
                    end
                end
            end
        end
    end

endmodule
